// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags, CDB snoop,
// same-cycle read forwarding, flush and busy count.
//
// Ports:
//   CLK, CLR            clock (rising) / async active-high reset
//   issue_en/rd/tag/data  rename (tag!=0) or plain write (tag==0) of issue_rd
//   rd_en, rd0/1_num    capture two source operands (registered, 1-cycle latency)
//   rd0/1_tag, rd0/1_data  sampled tag (0 = data valid) and value
//   cdb_valid/tag/data  result broadcast; releases every reg waiting on cdb_tag
//   flush               clear all tags, data kept
//   busy_cnt            number of registers with a nonzero tag
module reg_status_file #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  parameter  int TAG_W  = 3,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              issue_en,
  input  logic [IDX_W-1:0]  issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd0_num,
  input  logic [IDX_W-1:0]  rd1_num,
  output logic [TAG_W-1:0]  rd0_tag,
  output logic [DATA_W-1:0] rd0_data,
  output logic [TAG_W-1:0]  rd1_tag,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic [IDX_W:0]    busy_cnt
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [TAG_W-1:0]  tag_q  [NREG];
  logic [TAG_W-1:0]  tag_d  [NREG];

  logic [TAG_W-1:0]  rd0_tag_q, rd0_tag_d;
  logic [TAG_W-1:0]  rd1_tag_q, rd1_tag_d;
  logic [DATA_W-1:0] rd0_data_q, rd0_data_d;
  logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
  logic [IDX_W:0]    busy_q, busy_d;

  always_comb begin
    regs_d     = regs_q;
    tag_d      = tag_q;
    rd0_tag_d  = rd0_tag_q;
    rd1_tag_d  = rd1_tag_q;
    rd0_data_d = rd0_data_q;
    rd1_data_d = rd1_data_q;
    busy_d     = '0;

    if (cdb_valid && cdb_tag != '0) begin
      for (int i = 0; i < NREG; i++) begin
        if (tag_q[i] == cdb_tag) begin
          regs_d[i] = cdb_data;
          tag_d[i]  = '0;
        end
      end
    end

    // Reads see the CDB release but not this cycle's rename.
    if (rd_en) begin
      rd0_tag_d = tag_d[rd0_num];
      rd1_tag_d = tag_d[rd1_num];
      if (tag_d[rd0_num] == '0)
        rd0_data_d = regs_d[rd0_num];
      if (tag_d[rd1_num] == '0)
        rd1_data_d = regs_d[rd1_num];
    end

    if (issue_en) begin
      tag_d[issue_rd] = issue_tag;
      if (issue_tag == '0)
        regs_d[issue_rd] = issue_data;
    end

    if (flush) begin
      for (int i = 0; i < NREG; i++)
        tag_d[i] = '0;
    end

    for (int i = 0; i < NREG; i++) begin
      if (tag_d[i] != '0)
        busy_d = busy_d + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      rd0_tag_q  <= '0;
      rd1_tag_q  <= '0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
      busy_q     <= '0;
    end else begin
      regs_q     <= regs_d;
      tag_q      <= tag_d;
      rd0_tag_q  <= rd0_tag_d;
      rd1_tag_q  <= rd1_tag_d;
      rd0_data_q <= rd0_data_d;
      rd1_data_q <= rd1_data_d;
      busy_q     <= busy_d;
    end
  end

  assign rd0_tag  = rd0_tag_q;
  assign rd1_tag  = rd1_tag_q;
  assign rd0_data = rd0_data_q;
  assign rd1_data = rd1_data_q;
  assign busy_cnt = busy_q;

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: directed scenarios then random
// traffic against a behavioural register/tag model.
module tb_reg_status_file;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        issue_en = 1'b0;
  logic [2:0]  issue_rd = '0;
  logic [2:0]  issue_tag = '0;
  logic [15:0] issue_data = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd0_num = '0;
  logic [2:0]  rd1_num = '0;
  logic [2:0]  rd0_tag, rd1_tag;
  logic [15:0] rd0_data, rd1_data;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        flush = 1'b0;
  logic [3:0]  busy_cnt;

  reg_status_file #(.DATA_W(16), .NREG(8), .TAG_W(3)) dut (
    .CLK(CLK), .CLR(CLR),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .issue_tag(issue_tag), .issue_data(issue_data),
    .rd_en(rd_en), .rd0_num(rd0_num), .rd1_num(rd1_num),
    .rd0_tag(rd0_tag), .rd0_data(rd0_data),
    .rd1_tag(rd1_tag), .rd1_data(rd1_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  t0;
    logic [15:0] d0;
    logic [2:0]  t1;
    logic [15:0] d1;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // reference state
  int m_reg[8];
  int m_tag[8];
  exp_t cur;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: outputs of the edge just passed
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("busy_cnt", int'(busy_cnt), e.busy);
      chk("rd0_tag", int'(rd0_tag), int'(e.t0));
      chk("rd1_tag", int'(rd1_tag), int'(e.t1));
      if (e.t0 == 0) chk("rd0_data", int'(rd0_data), int'(e.d0));
      if (e.t1 == 0) chk("rd1_data", int'(rd1_data), int'(e.d1));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 0;
      m_tag[i] = 0;
    end
    cur.t0 = '0; cur.d0 = '0; cur.t1 = '0; cur.d1 = '0; cur.busy = 0;
  endtask

  task automatic cyc(input logic clr,
                     input logic ie, input int ird, input int itag,
                     input int idata,
                     input logic re, input int r0, input int r1,
                     input logic cv, input int ct, input int cd,
                     input logic fl);
    @(negedge CLK);
    #1;
    CLR = clr;
    issue_en = ie; issue_rd = 3'(ird); issue_tag = 3'(itag);
    issue_data = 16'(idata);
    rd_en = re; rd0_num = 3'(r0); rd1_num = 3'(r1);
    cdb_valid = cv; cdb_tag = 3'(ct); cdb_data = 16'(cd);
    flush = fl;
    if (clr) begin
      model_reset();
      #1;
      chk("clr_rd0_tag", int'(rd0_tag), 0);
      chk("clr_rd0_data", int'(rd0_data), 0);
      chk("clr_rd1_tag", int'(rd1_tag), 0);
      chk("clr_rd1_data", int'(rd1_data), 0);
      chk("clr_busy", int'(busy_cnt), 0);
    end else begin
      if (cv && ct != 0)
        for (int i = 0; i < 8; i++)
          if (m_tag[i] == ct) begin
            m_reg[i] = cd & 16'hFFFF;
            m_tag[i] = 0;
          end
      if (re) begin
        cur.t0 = 3'(m_tag[r0]);
        cur.t1 = 3'(m_tag[r1]);
        if (m_tag[r0] == 0) cur.d0 = 16'(m_reg[r0]);
        if (m_tag[r1] == 0) cur.d1 = 16'(m_reg[r1]);
      end
      if (ie) begin
        m_tag[ird] = itag;
        if (itag == 0) m_reg[ird] = idata & 16'hFFFF;
      end
      if (fl)
        for (int i = 0; i < 8; i++) m_tag[i] = 0;
      cur.busy = 0;
      for (int i = 0; i < 8; i++)
        if (m_tag[i] != 0) cur.busy++;
    end
    exp_q.push_back(cur);
  endtask

  task automatic idle();
    cyc(0, 0,0,0,0, 0,0,0, 0,0,0, 0);
  endtask

  initial begin
    model_reset();
    CLR = 1'b1;
    #12;
    // 1: reset state read
    cyc(1, 0,0,0,0, 1,3,5, 0,0,0, 0);
    cyc(0, 0,0,0,0, 1,3,5, 0,0,0, 0);
    // 2: plain write then read
    cyc(0, 1,2,0,'h1234, 0,0,0, 0,0,0, 0);
    cyc(0, 0,0,0,0, 1,2,3, 0,0,0, 0);
    // 3: rename, then CDB forwarded into same-cycle read
    cyc(0, 1,4,5,0, 0,0,0, 0,0,0, 0);
    cyc(0, 0,0,0,0, 1,4,2, 0,0,0, 0);
    cyc(0, 0,0,0,0, 1,4,2, 1,5,'hBEEF, 0);
    // 4: duplicate tags released by one broadcast
    cyc(0, 1,1,3,0, 0,0,0, 0,0,0, 0);
    cyc(0, 1,6,3,0, 1,1,6, 0,0,0, 0);
    cyc(0, 0,0,0,0, 1,1,6, 1,3,'h00AA, 0);
    // 5: read sees old state during same-cycle rename
    cyc(0, 1,1,0,'h0007, 0,0,0, 0,0,0, 0);
    cyc(0, 1,1,2,0, 1,1,0, 0,0,0, 0);
    cyc(0, 0,0,0,0, 1,1,0, 0,0,0, 0);
    // 6: issue overrides CDB hit, flush, mid-run clear
    cyc(0, 1,3,6,0, 0,0,0, 0,0,0, 0);
    cyc(0, 1,3,7,0, 1,3,1, 1,6,'h0F0F, 0);
    cyc(0, 0,0,0,0, 1,3,1, 0,0,0, 0);
    cyc(0, 0,0,0,0, 0,0,0, 0,0,0, 1);
    cyc(0, 0,0,0,0, 1,3,1, 0,0,0, 0);
    cyc(0, 1,5,4,0, 0,0,0, 0,0,0, 0);
    cyc(1, 1,6,2,0, 1,3,5, 1,4,'h5555, 0);
    cyc(0, 0,0,0,0, 1,3,5, 0,0,0, 0);
    // all registers busy: full-range busy count
    for (int i = 0; i < 8; i++)
      cyc(0, 1,i,(i%7)+1,0, 0,0,0, 0,0,0, 0);
    idle();
    for (int t = 1; t < 8; t++)
      cyc(0, 0,0,0,0, 1,t,t-1, 1,t,16'($urandom), 0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      int it;
      it = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
      cyc(0,
          1'($urandom), int'($urandom_range(0, 7)), it, int'(16'($urandom)),
          1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          1'($urandom), int'($urandom_range(0, 7)), int'(16'($urandom)),
          $urandom_range(0, 19) == 0);
    end
    idle();
    @(negedge CLK);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
